// File: rtl/aes_pkg.sv
// Shared AES definitions: word/block types, key-schedule constants, S-box, GF(2^8) doubling.
package aes_pkg;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_block_t;

  localparam int AES_NK = 4;
  localparam int AES_NR = 10;

  typedef enum logic {ST_IDLE, ST_EMIT} ks_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aesRotateWord.sv
// RotWord stage: cyclic left rotation of a word by one byte, bypassable.
module aesRotateWord
  import aes_pkg::*;
(
  input  logic      disableRotate,
  input  aes_word_t word,
  output aes_word_t rotated
);

  // Rotate {a0,a1,a2,a3} to {a1,a2,a3,a0} unless bypassed.
  always_comb begin
    rotated = disableRotate ? word : {word[23:0], word[31:24]};
  end

endmodule

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word; shared with SubBytes.
module aes_sub_word
  import aes_pkg::*;
(
  input  aes_word_t word,
  output aes_word_t subbed
);

  // Independent byte-wise substitution.
  always_comb begin
    subbed = '0;
    for (int i = 0; i < 4; i++) begin
      subbed[8*i +: 8] = SBOX[word[8*i +: 8]];
    end
  end

endmodule

// File: rtl/aes_key_expand128.sv
// AES-128 key schedule sequencer: emits rk0..rk10, one per valid/ready handshake.
//
// state   | meaning
// ST_IDLE | no expansion in flight; rk_data holds last key (or zero after reset)
// ST_EMIT | rk_data/rk_round hold a valid round key awaiting acceptance
module aes_key_expand128
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  aes_block_t  key_in,
  output logic        busy,
  output logic        rk_valid,
  input  logic        rk_ready,
  output aes_block_t  rk_data,
  output logic [3:0]  rk_round,
  output logic        done
);

  ks_state_t  state, state_next;
  logic [7:0] rcon;
  logic       load, advance, finish;
  aes_word_t  rot_w, sub_w, temp, chain;
  aes_block_t next_key;

  assign rk_valid = (state == ST_EMIT);
  assign busy     = (state == ST_EMIT);

  aesRotateWord u_rot (
    .disableRotate (1'b0),
    .word          (rk_data[31:0]),
    .rotated       (rot_w)
  );

  aes_sub_word u_sub (
    .word   (rot_w),
    .subbed (sub_w)
  );

  // Next round key: each word folds in the freshly computed word before it.
  always_comb begin
    temp     = sub_w ^ {rcon, 24'h0};
    chain    = temp;
    next_key = '0;
    for (int i = 0; i < AES_NK; i++) begin
      chain = rk_data[127-32*i -: 32] ^ chain;
      next_key[127-32*i -: 32] = chain;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state and datapath control; start is ignored while emitting.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (rk_ready) begin
          if (rk_round == 4'(AES_NR)) begin
            finish     = 1'b1;
            state_next = ST_IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Key, round and rcon registers; held bit-stable when neither loading nor advancing.
  always_ff @(posedge clk) begin
    if (reset) begin
      rk_data  <= '0;
      rk_round <= '0;
      rcon     <= 8'h01;
      done     <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        rk_data  <= key_in;
        rk_round <= '0;
        rcon     <= 8'h01;
      end else if (advance) begin
        rk_data  <= next_key;
        rk_round <= rk_round + 4'd1;
        rcon     <= xtime(rcon);
      end
    end
  end

endmodule

// File: tb/tb_aes_key_expand128.sv
// Self-checking bench for aes_key_expand128: scoreboard of model round keys plus directed checks.
module tb_aes_key_expand128;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy, rk_valid, done;
  logic         rk_ready = 1'b1;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;

  int tests = 0;
  int fails = 0;

  logic [131:0] sb[$];
  logic [7:0]   tb_sbox [256];

  localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] A_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A_RK4   = 128'hef44a541a8525b7fb671253bdb0bad00;
  localparam logic [127:0] A_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_RK1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_expand128 dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_data  (rk_data),
    .rk_round (rk_round),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box derived from the GF(2^8) inverse plus the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      tb_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic push_expansion(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {tb_sbox[t[31:24]], tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      sb.push_back({4'(r), w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
  endtask

  // Every accepted round key is checked against the scoreboard head.
  always @(negedge clk) begin
    logic [131:0] e;
    if (!reset && rk_valid && rk_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 128'(sb.size()), 128'd1);
      end else begin
        e = sb.pop_front();
        chk("sb_round", 128'(rk_round), 128'(e[131:128]));
        chk("sb_data", rk_data, e[127:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_round(input logic [3:0] r);
    for (int c = 0; c < 50 && rk_round != r; c++) step();
    chk("wait_round", 128'(rk_round), 128'(r));
  endtask

  task automatic wait_done();
    for (int c = 0; c < 100 && !done; c++) step();
    chk("done_seen", 128'(done), 128'd1);
    chk("busy_after_done", 128'(busy), 128'd0);
    chk("sb_empty", 128'(sb.size()), 128'd0);
  endtask

  // Full-rate expansion with rk_ready held high, checking key landmarks and rcon per round.
  task automatic run_full(input logic [127:0] key, input logic [127:0] rk1, input logic [127:0] rk10);
    logic [7:0] rcon_exp [10];
    rcon_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    rk_ready = 1'b1;
    key_in = key;
    start = 1'b1;
    push_expansion(key);
    step();
    start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk("valid_run", 128'(rk_valid), 128'd1);
      chk("round_run", 128'(rk_round), 128'(i));
      if (i == 0) chk("rk0", rk_data, key);
      if (i == 1) chk("rk1", rk_data, rk1);
      if (i == 10) chk("rk10", rk_data, rk10);
      if (i < 10) chk("rcon", 128'(dut.rcon), 128'(rcon_exp[i]));
    end
    @(negedge clk);
    chk("done_pulse", 128'(done), 128'd1);
    chk("valid_end", 128'(rk_valid), 128'd0);
    chk("busy_end", 128'(busy), 128'd0);
    chk("rk10_held", rk_data, rk10);
    @(negedge clk);
    chk("done_low", 128'(done), 128'd0);
    chk("sb_empty_full", 128'(sb.size()), 128'd0);
    step();
  endtask

  initial begin
    bit stalled;
    build_sbox();
    repeat (3) step();
    @(negedge clk);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_valid", 128'(rk_valid), 128'd0);
    chk("rst_data", rk_data, 128'd0);
    chk("rst_round", 128'(rk_round), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_rcon", 128'(dut.rcon), 128'h01);
    step();
    reset = 1'b0;
    step();

    run_full(KEY_A, A_RK1, A_RK10);
    run_full('0, Z_RK1, Z_RK10);

    // Back-pressure: random ready, plus a forced 5-cycle stall on rk4.
    key_in = KEY_A;
    start = 1'b1;
    push_expansion(KEY_A);
    step();
    start = 1'b0;
    stalled = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (done) break;
      if (rk_valid && rk_round == 4'd4 && !stalled) begin
        stalled = 1'b1;
        rk_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          step();
          chk("bp_hold_data", rk_data, A_RK4);
          chk("bp_hold_round", 128'(rk_round), 128'd4);
        end
      end
      rk_ready = 1'($urandom_range(0, 1));
      step();
    end
    chk("bp_stalled", 128'(stalled), 128'd1);
    wait_done();
    rk_ready = 1'b1;
    step();

    // start while busy is ignored; start after done begins a fresh expansion.
    key_in = KEY_A;
    start = 1'b1;
    push_expansion(KEY_A);
    step();
    start = 1'b0;
    wait_round(4'd3);
    key_in = KEY_B;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done();
    key_in = '0;
    start = 1'b1;
    push_expansion('0);
    step();
    start = 1'b0;
    chk("restart_round", 128'(rk_round), 128'd0);
    chk("restart_data", rk_data, 128'd0);
    wait_done();
    step();

    // Reset mid-expansion discards the in-flight key.
    key_in = KEY_A;
    start = 1'b1;
    push_expansion(KEY_A);
    step();
    start = 1'b0;
    wait_round(4'd6);
    reset = 1'b1;
    step();
    chk("mid_rst_valid", 128'(rk_valid), 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_data", rk_data, 128'd0);
    chk("mid_rst_round", 128'(rk_round), 128'd0);
    chk("mid_rst_rcon", 128'(dut.rcon), 128'h01);
    sb.delete();
    reset = 1'b0;
    step();
    run_full(KEY_A, A_RK1, A_RK10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
